// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encoding, address defaults
// and the sequential fetch step.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    TRAP  = 2'd3
  } pcseq_state_e;

  localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;
  localparam logic [31:0] PC_STEP            = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-address priority select: eret > jump > branch > pending redirect > pc+4.
// Redirect targets are passed through unaligned; the caller decides how to treat low bits.
module pc_next_mux
  import pc_sequencer_pkg::*;
(
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        pend_valid_i,
  input  logic [31:0] pend_addr_i,
  input  logic [31:0] pc_current_i,
  output logic        live_o,
  output logic [31:0] live_target_o,
  output logic        redirect_o,
  output logic [31:0] sel_raw_o
);

  always_comb begin
    live_o        = eret_i | jump_i | branch_i;
    live_target_o = branch_target_i;
    if (jump_i) live_target_o = jump_target_i;
    if (eret_i) live_target_o = epc_i;

    redirect_o = live_o | pend_valid_i;
    if (live_o)            sel_raw_o = live_target_o;
    else if (pend_valid_i) sel_raw_o = pend_addr_i;
    else                   sel_raw_o = pc_current_i + PC_STEP;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC write-port controller with imem req/ack handshake and stall hold.
// Optional macro PCSEQ_MISALIGN_TRAP_EN: misaligned redirect targets trap instead of being cleared.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        eret,
  input  logic        exception,
  input  logic [31:0] pc_current,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] next_pc,
  output logic        pc_write,
  output logic        fetch_valid,
  output logic [31:0] epc,
  output logic        misalign
);

  pcseq_state_e state_q, state_d;
  logic [31:0]  epc_q, epc_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_addr_q, pend_addr_d;

  logic        live;
  logic [31:0] live_target;
  logic        redirect;
  logic [31:0] sel_raw;
  logic [31:0] sel_addr;
  logic        bad;

  pc_next_mux u_mux (
    .eret_i          (eret),
    .epc_i           (epc_q),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .branch_i        (branch_taken),
    .branch_target_i (branch_target),
    .pend_valid_i    (pend_valid_q),
    .pend_addr_i     (pend_addr_q),
    .pc_current_i    (pc_current),
    .live_o          (live),
    .live_target_o   (live_target),
    .redirect_o      (redirect),
    .sel_raw_o       (sel_raw)
  );

`ifdef PCSEQ_MISALIGN_TRAP_EN
  assign sel_addr = sel_raw;
  assign bad      = redirect & (sel_raw[1:0] != 2'b00);
`else
  assign sel_addr = redirect ? word_align(sel_raw) : sel_raw;
  assign bad      = 1'b0;
`endif

  assign epc = epc_q;

  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    imem_req     = 1'b0;
    imem_addr    = '0;
    next_pc      = RESET_ADDR;
    pc_write     = 1'b0;
    fetch_valid  = 1'b0;
    misalign     = 1'b0;

    case (state_q)
      // BOOT is also the state held while reset is asserted; the write waits for release.
      BOOT: begin
        pc_write = ~reset;
        state_d  = FETCH;
      end
      FETCH, HOLD: begin
        next_pc = sel_addr;
        if (state_q == FETCH) begin
          imem_req  = 1'b1;
          imem_addr = pc_current;
        end
        if (exception) begin
          state_d = TRAP;
          epc_d   = pc_current;
        end else if (state_q == HOLD || imem_ack) begin
          fetch_valid = 1'b1;
          if (stall) begin
            state_d = HOLD;
          end else if (bad) begin
            misalign = 1'b1;
            epc_d    = sel_raw;
            state_d  = TRAP;
          end else begin
            pc_write = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      TRAP: begin
        pc_write = 1'b1;
        next_pc  = EXC_VECTOR;
        state_d  = FETCH;
      end
      default: state_d = BOOT;
    endcase

    // Any PC write consumes the pending redirect; otherwise a live pulse is remembered.
    if (pc_write) begin
      pend_valid_d = 1'b0;
    end else if (live && !exception && (state_q == FETCH || state_q == HOLD)) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = live_target;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      epc_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a flag-based reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] EXC_A = 32'h0000_0080;

  logic        clock = 1'b0;
  logic        reset, stall, branch_taken, jump, eret, exception, imem_ack;
  logic [31:0] branch_target, jump_target, pc_current;
  logic        imem_req, pc_write, fetch_valid, misalign;
  logic [31:0] imem_addr, next_pc, epc;

  pc_sequencer #(.RESET_ADDR(RST_A), .EXC_VECTOR(EXC_A)) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .eret          (eret),
    .exception     (exception),
    .pc_current    (pc_current),
    .imem_ack      (imem_ack),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .next_pc       (next_pc),
    .pc_write      (pc_write),
    .fetch_valid   (fetch_valid),
    .epc           (epc),
    .misalign      (misalign)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: activity flags rather than an encoded state.
  bit          m_boot, m_hold, m_trap, m_pv;
  logic [31:0] m_epc, m_pa;
  bit          n_boot, n_hold, n_trap, n_pv;
  logic [31:0] n_epc, n_pa;
  bit          e_req, e_pw, e_fv, e_mis;
  logic [31:0] e_addr, e_next;
  logic [31:0] pc_reg;

  task automatic settle();
    bit          live, redir, bad;
    logic [31:0] tgt, sel_raw, sel;
    @(negedge clock);
    if (reset) begin
      m_boot = 1; m_hold = 0; m_trap = 0; m_pv = 0; m_epc = '0; m_pa = '0;
    end
    live = eret | jump | branch_taken;
    if (eret)              tgt = m_epc;
    else if (jump)         tgt = jump_target;
    else                   tgt = branch_target;
    redir = live | m_pv;
    if (live)              sel_raw = tgt;
    else if (m_pv)         sel_raw = m_pa;
    else                   sel_raw = pc_current + 32'd4;
`ifdef PCSEQ_MISALIGN_TRAP_EN
    bad = redir && (sel_raw[1:0] != 2'b00);
    sel = sel_raw;
`else
    bad = 0;
    sel = redir ? (sel_raw & 32'hFFFF_FFFC) : sel_raw;
`endif
    e_req = 0; e_addr = '0; e_next = RST_A; e_pw = 0; e_fv = 0; e_mis = 0;
    n_boot = m_boot; n_hold = m_hold; n_trap = m_trap; n_pv = m_pv; n_epc = m_epc; n_pa = m_pa;
    if (reset) begin
      n_boot = 1;
    end else if (m_boot) begin
      e_pw = 1; n_boot = 0;
    end else if (m_trap) begin
      e_pw = 1; e_next = EXC_A; n_trap = 0;
    end else begin
      e_next = sel;
      if (!m_hold) begin e_req = 1; e_addr = pc_current; end
      if (exception) begin
        n_trap = 1; n_hold = 0; n_epc = pc_current;
      end else if (m_hold || imem_ack) begin
        e_fv = 1;
        if (stall) n_hold = 1;
        else if (bad) begin e_mis = 1; n_epc = sel_raw; n_trap = 1; n_hold = 0; end
        else begin e_pw = 1; n_hold = 0; end
      end
    end
    if (e_pw) n_pv = 0;
    else if (live && !reset && !m_boot && !m_trap && !exception) begin n_pv = 1; n_pa = tgt; end

    chk("pc_write",    32'(pc_write),    32'(e_pw));
    chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
    chk("imem_req",    32'(imem_req),    32'(e_req));
    chk("imem_addr",   imem_addr,        e_addr);
    chk("misalign",    32'(misalign),    32'(e_mis));
    chk("epc",         epc,              m_epc);
    if (e_pw || reset) chk("next_pc", next_pc, e_next);
  endtask

  task automatic advance();
    @(posedge clock);
    m_boot = n_boot; m_hold = n_hold; m_trap = n_trap; m_pv = n_pv; m_epc = n_epc; m_pa = n_pa;
    if (e_pw) pc_reg = e_next;
    #1;
    jump = 0; eret = 0; branch_taken = 0; exception = 0; imem_ack = 0;
    pc_current = pc_reg;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; stall = 0; branch_taken = 0; jump = 0; eret = 0; exception = 0; imem_ack = 0;
    branch_target = '0; jump_target = '0; pc_current = '0; pc_reg = '0;
    m_boot = 1; m_hold = 0; m_trap = 0; m_pv = 0; m_epc = '0; m_pa = '0;
    #1;
    settle(); chk("rst_pw", 32'(pc_write), 32'd0); chk("rst_next", next_pc, 32'h0); advance();
    settle(); advance();
    reset = 0;
    settle(); chk("boot_pw", 32'(pc_write), 32'd1); chk("boot_next", next_pc, 32'h0); advance();
    settle(); chk("fetch_req", 32'(imem_req), 32'd1); advance();

    pc_current = 32'h100; imem_ack = 1;
    settle(); chk("ack_next", next_pc, 32'h104); chk("ack_fv", 32'(fetch_valid), 32'd1); advance();

    jump = 1; jump_target = 32'h2000;
    settle(); chk("jump_nowrite", 32'(pc_write), 32'd0); advance();
    imem_ack = 1;
    settle(); chk("pend_next", next_pc, 32'h2000); advance();
    imem_ack = 1;
    settle(); chk("pend_clear", next_pc, 32'h2004); advance();

    stall = 1; imem_ack = 1;
    settle(); chk("stall_ack_pw", 32'(pc_write), 32'd0); advance();
    repeat (3) begin
      settle();
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_fv", 32'(fetch_valid), 32'd1);
      advance();
    end
    stall = 0;
    settle(); chk("unstall_pw", 32'(pc_write), 32'd1); chk("unstall_next", next_pc, 32'h2008); advance();
    settle(); chk("refetch_req", 32'(imem_req), 32'd1); advance();

    pc_current = 32'h340; exception = 1; imem_ack = 1;
    settle(); chk("exc_fv", 32'(fetch_valid), 32'd0); chk("exc_pw", 32'(pc_write), 32'd0); advance();
    settle(); chk("trap_epc", epc, 32'h340); chk("trap_next", next_pc, 32'h80); advance();
    eret = 1; imem_ack = 1;
    settle(); chk("eret_next", next_pc, 32'h340); advance();

    pc_current = 32'hFFFF_FFFC; imem_ack = 1;
    settle(); chk("wrap_next", next_pc, 32'h0); advance();

    branch_taken = 1; branch_target = 32'h1002; imem_ack = 1;
    settle();
`ifdef PCSEQ_MISALIGN_TRAP_EN
    chk("mis_pulse", 32'(misalign), 32'd1); chk("mis_pw", 32'(pc_write), 32'd0); advance();
    settle(); chk("mis_epc", epc, 32'h1002); advance();
`else
    chk("align_next", next_pc, 32'h1000); chk("align_mis", 32'(misalign), 32'd0); advance();
`endif

    settle(); advance();
    reset = 1; imem_ack = 1;
    settle(); chk("rstmid_req", 32'(imem_req), 32'd0); chk("rstmid_fv", 32'(fetch_valid), 32'd0); advance();
    reset = 0;
    settle(); chk("reboot_pw", 32'(pc_write), 32'd1); advance();

    repeat (600) begin
      reset        = ($urandom_range(99) == 0);
      stall        = ($urandom_range(3) == 0);
      imem_ack     = $urandom_range(1) == 1;
      jump         = ($urandom_range(9) == 0);
      eret         = ($urandom_range(14) == 0);
      branch_taken = ($urandom_range(7) == 0);
      exception    = ($urandom_range(19) == 0);
      jump_target   = $urandom;
      branch_target = $urandom;
      if ($urandom_range(3) != 0) jump_target[1:0] = 2'b00;
      if ($urandom_range(3) != 0) branch_target[1:0] = 2'b00;
      if ($urandom_range(7) == 0) pc_current = $urandom & 32'hFFFF_FFFC;
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
